// File: rtl/branch_stack_pkg.sv
// Shared sizes and types for the R10K branch checkpoint stack.
package branch_stack_pkg;

    localparam int BRANCH_STACK_DEPTH = 4;
    localparam int BRANCH_TAG_BITS    = $clog2(BRANCH_STACK_DEPTH);
    localparam int PHYS_REG_SZ_R10K   = 64;

    typedef logic [BRANCH_TAG_BITS-1:0]    BRANCH_TAG;
    typedef logic [BRANCH_STACK_DEPTH-1:0] BRANCH_MASK;
    typedef logic [PHYS_REG_SZ_R10K-1:0]   FREE_LIST;

endpackage

// File: rtl/branch_stack_psel.sv
// Single-requestor priority select plus encoder: lowest set bit of req.
module branch_stack_psel #(
    parameter int WIDTH    = 4,
    parameter int TAG_BITS = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]    req,
    output logic [TAG_BITS-1:0] tag,
    output logic                found
);

    // Scan from the top so the lowest-index request wins.
    always_comb begin
        tag   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                tag   = TAG_BITS'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_stack.sv
// Checkpoint stack for R10K-style branch recovery: snapshots the free list
// per branch and produces restore/squash/clear on resolution.
module branch_stack
    import branch_stack_pkg::*;
#(
    parameter int DEPTH          = BRANCH_STACK_DEPTH,
    parameter int TAG_BITS       = $clog2(DEPTH),
    parameter int PHYS_SZ        = PHYS_REG_SZ_R10K,
    parameter bit CHECK_PROTOCOL = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                dispatch_branch_valid,
    input  logic [PHYS_SZ-1:0]  dispatch_free_list,
    input  logic                resolve_valid,
    input  logic [TAG_BITS-1:0] resolve_tag,
    input  logic                resolve_mispredict,
    output logic [TAG_BITS-1:0] alloc_tag,
    output logic                stack_full,
    output logic [DEPTH-1:0]    live_mask,
    output logic                restore_flag,
    output logic [PHYS_SZ-1:0]  free_list_restore,
    output logic [DEPTH-1:0]    squash_mask,
    output logic [DEPTH-1:0]    clear_mask
);

    logic [DEPTH-1:0]   valid;
    logic [PHYS_SZ-1:0] snapshot   [DEPTH];
    logic [DEPTH-1:0]   older_mask [DEPTH];

    logic               resolve_hit;
    logic               mispredict;
    logic               correct;
    logic               alloc;
    logic               free_found;
    logic [DEPTH-1:0]   tag_onehot;
    logic [DEPTH-1:0]   younger;
    logic [DEPTH-1:0]   kill_mask;

    branch_stack_psel #(
        .WIDTH    (DEPTH),
        .TAG_BITS (TAG_BITS)
    ) free_slot_sel (
        .req   (~valid),
        .tag   (alloc_tag),
        .found (free_found)
    );

    assign stack_full  = ~free_found;
    assign live_mask   = valid;

    assign resolve_hit = resolve_valid & valid[resolve_tag];
    assign mispredict  = resolve_hit & resolve_mispredict;
    assign correct     = resolve_hit & ~resolve_mispredict;
    assign tag_onehot  = DEPTH'(1) << resolve_tag;

    // A slot is younger than the resolving branch if the resolving slot was
    // live when it was allocated.
    always_comb begin
        younger = '0;
        for (int s = 0; s < DEPTH; s++) begin
            younger[s] = valid[s] & older_mask[s][resolve_tag];
        end
    end

    assign squash_mask       = mispredict ? (tag_onehot | younger) : '0;
    assign clear_mask        = correct ? tag_onehot : '0;
    assign kill_mask         = squash_mask | clear_mask;
    assign restore_flag      = mispredict;
    assign free_list_restore = mispredict ? snapshot[resolve_tag] : '0;

    assign alloc = dispatch_branch_valid & ~stack_full & ~mispredict;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                snapshot[s]   <= '0;
                older_mask[s] <= '0;
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (alloc && (alloc_tag == TAG_BITS'(s))) begin
                    valid[s]      <= 1'b1;
                    snapshot[s]   <= dispatch_free_list;
                    older_mask[s] <= valid & ~kill_mask;
                end else begin
                    valid[s]      <= valid[s] & ~kill_mask[s];
                    older_mask[s] <= older_mask[s] & ~kill_mask;
                end
            end
        end
    end

    // Dispatching into a full stack is a protocol violation; it is dropped.
    always @(posedge clock) begin
        if (CHECK_PROTOCOL && reset_n) begin
            assert (!(dispatch_branch_valid && stack_full));
        end
    end

endmodule

// File: tb/tb_branch_stack.sv
// Directed self-checking bench for branch_stack.
module tb_branch_stack;
    import branch_stack_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       dispatch_branch_valid;
    FREE_LIST   dispatch_free_list;
    logic       resolve_valid;
    BRANCH_TAG  resolve_tag;
    logic       resolve_mispredict;
    BRANCH_TAG  alloc_tag;
    logic       stack_full;
    BRANCH_MASK live_mask;
    logic       restore_flag;
    FREE_LIST   free_list_restore;
    BRANCH_MASK squash_mask;
    BRANCH_MASK clear_mask;

    int checks = 0;
    int errors = 0;

    branch_stack #(
        .DEPTH          (BRANCH_STACK_DEPTH),
        .TAG_BITS       (BRANCH_TAG_BITS),
        .PHYS_SZ        (PHYS_REG_SZ_R10K),
        .CHECK_PROTOCOL (1'b0)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .dispatch_branch_valid (dispatch_branch_valid),
        .dispatch_free_list    (dispatch_free_list),
        .resolve_valid         (resolve_valid),
        .resolve_tag           (resolve_tag),
        .resolve_mispredict    (resolve_mispredict),
        .alloc_tag             (alloc_tag),
        .stack_full            (stack_full),
        .live_mask             (live_mask),
        .restore_flag          (restore_flag),
        .free_list_restore     (free_list_restore),
        .squash_mask           (squash_mask),
        .clear_mask            (clear_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        dispatch_branch_valid = 1'b0;
        dispatch_free_list    = '0;
        resolve_valid         = 1'b0;
        resolve_tag           = '0;
        resolve_mispredict    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_inputs();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic dispatch(input logic [63:0] fl);
        dispatch_branch_valid = 1'b1;
        dispatch_free_list    = fl;
        step();
        dispatch_branch_valid = 1'b0;
        #1;
    endtask

    task automatic resolve(input logic [1:0] tag, input logic misp);
        resolve_valid      = 1'b1;
        resolve_tag        = tag;
        resolve_mispredict = misp;
        #1;
    endtask

    task automatic fill_four();
        dispatch_branch_valid = 1'b1;
        dispatch_free_list    = 64'hF0;
        #1 check("fill_tag0", 64'(alloc_tag), 64'd0);
        step();
        dispatch_free_list = 64'hE0;
        #1 check("fill_tag1", 64'(alloc_tag), 64'd1);
        step();
        dispatch_free_list = 64'hC0;
        #1 check("fill_tag2", 64'(alloc_tag), 64'd2);
        step();
        dispatch_free_list = 64'h80;
        #1 check("fill_tag3", 64'(alloc_tag), 64'd3);
        step();
        dispatch_branch_valid = 1'b0;
        #1;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check("rst_live",    64'(live_mask),    64'h0);
        check("rst_full",    64'(stack_full),   64'h0);
        check("rst_alloc",   64'(alloc_tag),    64'h0);
        check("rst_restore", 64'(restore_flag), 64'h0);
        check("rst_flr",     free_list_restore, 64'h0);
        check("rst_squash",  64'(squash_mask),  64'h0);
        check("rst_clear",   64'(clear_mask),   64'h0);
        step();
        reset_n = 1'b1;
        #1;

        // Fill, overflow, then mispredict tag 1
        fill_four();
        check("full_live", 64'(live_mask),  64'hF);
        check("full_flag", 64'(stack_full), 64'h1);
        @(negedge clock);
        dispatch(64'h11);
        check("overflow_live", 64'(live_mask), 64'hF);
        @(negedge clock);
        resolve(2'd1, 1'b1);
        check("mp1_restore", 64'(restore_flag), 64'h1);
        check("mp1_flr",     free_list_restore, 64'hE0);
        check("mp1_squash",  64'(squash_mask),  64'hE);
        check("mp1_clear",   64'(clear_mask),   64'h0);
        step();
        idle_inputs();
        #1;
        check("mp1_live",  64'(live_mask), 64'h1);
        check("mp1_alloc", 64'(alloc_tag), 64'h1);

        // Correct resolve tag 0, then mispredict tag 2
        do_reset();
        @(negedge clock);
        fill_four();
        @(negedge clock);
        resolve(2'd0, 1'b0);
        check("cr0_clear",   64'(clear_mask),   64'h1);
        check("cr0_squash",  64'(squash_mask),  64'h0);
        check("cr0_restore", 64'(restore_flag), 64'h0);
        check("cr0_flr",     free_list_restore, 64'h0);
        step();
        idle_inputs();
        #1;
        check("cr0_live",  64'(live_mask), 64'hE);
        check("cr0_alloc", 64'(alloc_tag), 64'h0);
        @(negedge clock);
        resolve(2'd2, 1'b1);
        check("mp2_squash", 64'(squash_mask), 64'hC);
        check("mp2_flr",    free_list_restore, 64'hC0);
        step();
        idle_inputs();
        #1;
        check("mp2_live", 64'(live_mask), 64'h2);

        // Dispatch together with mispredict of the only live slot
        do_reset();
        @(negedge clock);
        dispatch(64'hAA);
        check("one_live", 64'(live_mask), 64'h1);
        @(negedge clock);
        dispatch_branch_valid = 1'b1;
        dispatch_free_list    = 64'h55;
        resolve(2'd0, 1'b1);
        check("dmp_squash", 64'(squash_mask), 64'h1);
        check("dmp_flr",    free_list_restore, 64'hAA);
        step();
        idle_inputs();
        #1;
        check("dmp_live",  64'(live_mask), 64'h0);
        check("dmp_alloc", 64'(alloc_tag), 64'h0);

        // Resolve of a non-live slot on an empty stack
        @(negedge clock);
        resolve(2'd3, 1'b1);
        check("nl_restore", 64'(restore_flag), 64'h0);
        check("nl_squash",  64'(squash_mask),  64'h0);
        check("nl_flr",     free_list_restore, 64'h0);
        check("nl_clear",   64'(clear_mask),   64'h0);
        step();
        idle_inputs();
        #1;
        check("nl_live", 64'(live_mask), 64'h0);

        // Dispatch together with a correct resolve: freed slot not reused yet
        @(negedge clock);
        dispatch(64'h33);
        @(negedge clock);
        dispatch_branch_valid = 1'b1;
        dispatch_free_list    = 64'h44;
        resolve(2'd0, 1'b0);
        check("dcr_alloc", 64'(alloc_tag),  64'h1);
        check("dcr_clear", 64'(clear_mask), 64'h1);
        step();
        idle_inputs();
        #1;
        check("dcr_live", 64'(live_mask), 64'h2);

        // Asynchronous reset in the middle of a mispredict
        do_reset();
        @(negedge clock);
        dispatch(64'h01);
        @(negedge clock);
        dispatch(64'h02);
        @(negedge clock);
        dispatch(64'h04);
        check("ar_live_pre", 64'(live_mask), 64'h7);
        @(negedge clock);
        resolve(2'd0, 1'b1);
        check("ar_restore_pre", 64'(restore_flag), 64'h1);
        #1 reset_n = 1'b0;
        #1;
        check("ar_live",    64'(live_mask),    64'h0);
        check("ar_restore", 64'(restore_flag), 64'h0);
        check("ar_flr",     free_list_restore, 64'h0);
        check("ar_squash",  64'(squash_mask),  64'h0);
        check("ar_alloc",   64'(alloc_tag),    64'h0);
        @(negedge clock);
        idle_inputs();
        reset_n = 1'b1;
        step();
        check("ar_live_post", 64'(live_mask), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_stack.md
Name: branch_stack

Overview:
- Checkpoint stack for R10K-style branch recovery. Captures the free-list bitvector at each dispatched branch.
- On a mispredict, drives free_list_restore/restore_flag into the free list. Broadcasts squash and clear masks to the ROB and RS.
- Sits beside dispatch: dispatch writes the checkpoint, execute resolves it, the free list consumes the restore.

Parameters:
- DEPTH, 4, number of checkpoint slots (max in-flight unresolved branches).
- TAG_BITS, $clog2(DEPTH), checkpoint tag width.
- PHYS_SZ, `PHYS_REG_SZ_R10K, free-list bitvector width.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- dispatch_branch_valid  in  1  dispatch is allocating a checkpoint this cycle.
- dispatch_free_list  in  PHYS_SZ  free list after this cycle's dispatch allocations; this is the snapshot value.
- resolve_valid  in  1  a branch resolves this cycle.
- resolve_tag  in  TAG_BITS  checkpoint tag of the resolving branch.
- resolve_mispredict  in  1  the resolving branch was mispredicted.
- alloc_tag  out  TAG_BITS  tag given to the next dispatched branch; meaningful only when !stack_full.
- stack_full  out  1  every slot is live.
- live_mask  out  DEPTH  valid bit per slot.
- restore_flag  out  1  mispredict restore is active this cycle.
- free_list_restore  out  PHYS_SZ  snapshot of the mispredicted checkpoint; 0 when restore_flag=0.
- squash_mask  out  DEPTH  slots squashed this cycle (resolving slot plus all younger slots).
- clear_mask  out  DEPTH  one-hot of a slot resolved as correctly predicted this cycle.

Behaviour:
- State per slot:
  - valid bit.
  - snapshot[PHYS_SZ].
  - older_mask[DEPTH]: the live slots at the moment this slot was allocated.
- Reset (async, reset_n=0): all valid=0, snapshots=0, older_masks=0.
- Output values while in reset: stack_full=0, live_mask=0, alloc_tag=0, restore_flag=0, free_list_restore=0, squash_mask=0, clear_mask=0.
- Reset asserted mid-operation clears all state immediately. No restore is emitted.
- alloc_tag is the lowest-index slot with valid=0, from a priority encoder.
- stack_full = &valid.
- resolve_hit = resolve_valid & valid[resolve_tag]. A resolve to a non-live slot is ignored: no outputs and no state change.
- Correct prediction (resolve_hit & !resolve_mispredict):
  - clear_mask = onehot(resolve_tag), driven combinationally in the same cycle.
  - Next edge: valid[tag]<=0, and bit tag is cleared from every slot's older_mask.
- Mispredict (resolve_hit & resolve_mispredict):
  - Zero-latency combinational outputs: restore_flag=1, free_list_restore=snapshot[resolve_tag].
  - squash_mask = onehot(tag) | {s : valid[s] & older_mask[s][tag]}.
  - Next edge: valid[s]<=0 for every s in squash_mask; the squashed slots' tag bits are cleared from all older_masks.
- Allocation (dispatch_branch_valid & !stack_full & !mispredict-this-cycle), at the next edge:
  - valid[alloc_tag]<=1.
  - snapshot<=dispatch_free_list.
  - older_mask<=valid, minus the slot being cleared this cycle (if any).
- Simultaneous dispatch and mispredict: the dispatched branch is younger and is dropped; no allocation.
- Simultaneous dispatch and correct resolve:
  - Allocation proceeds.
  - The slot freed this cycle is not reused until the next cycle, because alloc_tag is computed from the current valid bits.
- dispatch_branch_valid while stack_full is a protocol violation. The dispatch is ignored and a simulation assertion fires.
- Only one resolve per cycle. The free list computes next | free_list_restore, so snapshots never need updating on retire.
- Wrap-around: tags are unordered slots. Age comes only from older_mask, so reuse in any order is legal.

Decomposition:
- Shared package (sys_defs) carries:
  - BRANCH_TAG typedef, logic [TAG_BITS-1:0].
  - `BRANCH_STACK_DEPTH.
  - BRANCH_MASK typedef, logic [DEPTH-1:0].
- One sub-module: the existing psel_gen plus encoder pair (REQS=1) on ~valid produces alloc_tag. All else is inline.

Test Plan:
- Reset then 4 dispatches with free lists 0xF0, 0xE0, 0xC0, 0x80:
  - Required: alloc_tag 0,1,2,3; live_mask 0xF; stack_full=1.
  - A 5th dispatch is ignored (live_mask still 0xF).
- After above, mispredict tag 1:
  - Same cycle: restore_flag=1, free_list_restore=0xE0, squash_mask=0b1110.
  - Next cycle: live_mask=0b0001, alloc_tag=1.
- After the first scenario, correct-resolve tag 0:
  - clear_mask=0b0001; next cycle live_mask=0b1110, alloc_tag=0.
  - Then mispredict tag 2: squash_mask=0b1100 (tag 1 is unaffected).
- Same-cycle dispatch and mispredict of tag 0 with slots {0} live:
  - squash_mask=0b0001; next cycle live_mask=0, no allocation occurred.
- Resolve of non-live tag 3 with mispredict=1 on an empty stack:
  - restore_flag=0, squash_mask=0, state unchanged.
- With 3 slots live, pulse reset_n low mid-cycle:
  - All outputs are 0 immediately (asynchronous), live_mask=0 after release.
